// File: rtl/bit_serial_sub.sv
// bit_serial_sub
//   Bit-serial subtractor computing d = a - b - bin (mod 2^WIDTH) and the
//   final borrow-out. It uses one full-subtractor cell and a borrow flop,
//   and handles one bit per clock, LSB first.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   start : request pulse; accepted only in IDLE or DONE
//   a, b  : minuend / subtrahend, captured on an accepted start
//   bin   : borrow-in, captured on an accepted start
//   busy  : high while bits are being shifted through the cell
//   done  : one-cycle pulse when d/bout take their new value
//   d     : difference (updated only on the DONE transition)
//   bout  : final borrow-out, 1 iff a < b + bin
module bit_serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-subtractor cell working on the current LSBs.
  logic x, y, diff, br_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    x         = opa_q[0];
    y         = opb_q[0];
    diff      = x ^ y ^ br_q;
    br_nxt    = (~x & y) | (~(x ^ y) & br_q);
    // New bit enters at the MSB so the first (LSB) bit lands at bit 0
    // after WIDTH shifts.
    res_shift = {diff, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_SHIFT: begin
        res_d = res_shift;
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the full result in the same edge so d never
          // exposes a partially shifted value.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          d_d     = res_shift;
          bout_d  = br_nxt;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request (DONE gives back-to-back).
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          state_d = S_SHIFT;
          opa_d   = a;
          opb_d   = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_bit_serial_sub.sv
// Testbench for bit_serial_sub: a cycle-level behavioural model (arithmetic
// result plus a countdown to the done pulse) is compared against the DUT on
// every falling edge, and directed cases pin the model to literal values.
module tb_bit_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] d;
  logic         bout;

  int checks = 0;
  int errs   = 0;

  bit_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
  );

  always #5 clk = ~clk;

  // Behavioural model: pend counts cycles left until done.
  int           pend      = 0;
  logic [W-1:0] pend_d    = '0;
  logic         pend_bout = 1'b0;
  logic [W-1:0] m_d       = '0;
  logic         m_bout    = 1'b0;
  logic         m_done    = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W:0] r;
    logic       acc;
    if (rst) begin
      pend = 0; m_d = '0; m_bout = 1'b0; m_done = 1'b0;
    end else begin
      acc    = (pend == 0) && start;
      m_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          m_done = 1'b1;
          m_d    = pend_d;
          m_bout = pend_bout;
        end
      end
      if (acc) begin
        r         = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        pend_d    = r[W-1:0];
        pend_bout = r[W];
        pend      = W;
      end
    end
  end

  // Per-cycle compare process.
  always @(negedge clk) begin
    logic m_busy;
    m_busy = (pend > 0);
    checks++;
    if ({busy, done, d, bout} !== {m_busy, m_done, m_d, m_bout}) begin
      errs++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b d=%b bout=%b exp busy=%b done=%b d=%b bout=%b",
               $time, busy, done, d, bout, m_busy, m_done, m_d, m_bout);
    end
  end

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Waits (bounded) for done; returns number of falling edges seen.
  task automatic wait_done(input bit noise, output int n);
    n = 1;
    while (done !== 1'b1 && n < W + 4) begin
      if (noise) begin
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  // Issue one op at a falling edge; returns at the falling edge in DONE.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bi_n,
                        input bit noise, input bit lit, input logic [W-1:0] ed, input logic eb);
    int n;
    a = ai; b = bi; bin = bi_n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(noise, n);
    checks++;
    if (done !== 1'b1 || n != W + 1) begin
      errs++;
      $display("FAIL latency a=%b b=%b bin=%b got=%0d cycles done=%b exp=%0d", ai, bi, bi_n, n, done, W + 1);
    end
    if (lit) begin
      chk("lit_dut", {bout, d}, {eb, ed});
      chk("lit_model", {m_bout, m_d}, {eb, ed});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, d[W-2:0]}, {2'b00, {(W-1){1'b0}}});
    chk("reset_bout", {{W{1'b0}}, bout}, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'b0000, 4'b0000, 1'b0, 0, 1, 4'b0000, 1'b0);
    run_op(4'b0101, 4'b0011, 1'b0, 0, 1, 4'b0010, 1'b0);
    run_op(4'b0011, 4'b0101, 1'b0, 0, 1, 4'b1110, 1'b1);
    run_op(4'b0000, 4'b0000, 1'b1, 0, 1, 4'b1111, 1'b1);
    run_op(4'b1111, 4'b1111, 1'b1, 0, 1, 4'b1111, 1'b1);
    run_op(4'b1111, 4'b0000, 1'b0, 0, 1, 4'b1111, 1'b0);
    run_op(4'b0000, 4'b0001, 1'b0, 1, 1, 4'b1111, 1'b1);

    // Start during busy must be ignored.
    @(negedge clk);
    a = 4'b0111; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b0000; b = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, n);
    chk("ignore_start", {bout, d}, {1'b0, 4'b0110});
    // Back-to-back start from the DONE cycle.
    run_op(4'b1000, 4'b0001, 1'b0, 0, 1, 4'b0111, 1'b0);

    // Reset during cycle 2 of a busy op.
    @(negedge clk);
    a = 4'b1100; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_op", {busy, done, d[W-2:0]}, '0);
    chk("rst_mid_d", {bout, d}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {{W{1'b0}}, done}, '0);
    run_op(4'b1010, 4'b0101, 1'b1, 0, 1, 4'b0100, 1'b0);

    // Exhaustive sweep, back-to-back, with random input/start noise while busy.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          run_op(W'(i), W'(j), 1'(k), 1, 0, '0, 1'b0);

    // Random ops with idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1, 0, '0, 1'b0);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
